// File: rtl/merge_recirculador.sv
// merge_recirculador: four-lane merge stage in front of a recirculator.
// Each lane buffers new data in a small FIFO; recirculated data returned by
// the recirculator takes priority over the FIFO head on the lane output.
// A small control FSM tracks idle/active/error and drives backpressure.
module merge_recirculador #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic [DATA_WIDTH-1:0] dataIn0,
    input  logic [DATA_WIDTH-1:0] dataIn1,
    input  logic [DATA_WIDTH-1:0] dataIn2,
    input  logic [DATA_WIDTH-1:0] dataIn3,
    input  logic                  validIn0,
    input  logic                  validIn1,
    input  logic                  validIn2,
    input  logic                  validIn3,
    input  logic [DATA_WIDTH-1:0] recircIn0,
    input  logic [DATA_WIDTH-1:0] recircIn1,
    input  logic [DATA_WIDTH-1:0] recircIn2,
    input  logic [DATA_WIDTH-1:0] recircIn3,
    input  logic                  recircValid0,
    input  logic                  recircValid1,
    input  logic                  recircValid2,
    input  logic                  recircValid3,
    output logic [DATA_WIDTH-1:0] dataOut0,
    output logic [DATA_WIDTH-1:0] dataOut1,
    output logic [DATA_WIDTH-1:0] dataOut2,
    output logic [DATA_WIDTH-1:0] dataOut3,
    output logic                  validOut0,
    output logic                  validOut1,
    output logic                  validOut2,
    output logic                  validOut3,
    output logic                  selector_IDLE,
    output logic                  pause,
    output logic                  error
);

    localparam int LANES = 4;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_HIGH = CW'(FIFO_DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    state_t state_r;
    state_t state_fsm_s;
    state_t state_next_s;

    // Per-lane views of the flat port list
    logic [DATA_WIDTH-1:0] data_in_s   [LANES];
    logic [DATA_WIDTH-1:0] recirc_in_s [LANES];
    logic [LANES-1:0]      valid_in_s;
    logic [LANES-1:0]      recirc_valid_s;

    // Lane FIFO storage and bookkeeping
    logic [DATA_WIDTH-1:0] mem_r        [LANES][FIFO_DEPTH];
    logic [AW-1:0]         rd_ptr_r     [LANES];
    logic [AW-1:0]         wr_ptr_r     [LANES];
    logic [CW-1:0]         count_r      [LANES];
    logic [CW-1:0]         count_next_s [LANES];

    logic [LANES-1:0] push_s;
    logic [LANES-1:0] pop_s;
    logic [LANES-1:0] ovf_s;
    logic             any_valid_s;
    logic             any_high_s;
    logic             all_empty_next_s;
    logic             overflow_s;

    // Registered outputs
    logic [DATA_WIDTH-1:0] data_out_r [LANES];
    logic [LANES-1:0]      valid_out_r;
    logic                  selector_idle_r;
    logic                  pause_r;
    logic                  error_r;

    assign data_in_s[0]   = dataIn0;
    assign data_in_s[1]   = dataIn1;
    assign data_in_s[2]   = dataIn2;
    assign data_in_s[3]   = dataIn3;
    assign recirc_in_s[0] = recircIn0;
    assign recirc_in_s[1] = recircIn1;
    assign recirc_in_s[2] = recircIn2;
    assign recirc_in_s[3] = recircIn3;
    assign valid_in_s     = {validIn3, validIn2, validIn1, validIn0};
    assign recirc_valid_s = {recircValid3, recircValid2, recircValid1, recircValid0};

    assign any_valid_s = (|valid_in_s) | (|recirc_valid_s);
    assign overflow_s  = |ovf_s;

    // Lane push/pop decisions, next occupancy and the aggregate flags derived from it
    always_comb begin
        push_s           = {LANES{1'b0}};
        pop_s            = {LANES{1'b0}};
        ovf_s            = {LANES{1'b0}};
        any_high_s       = 1'b0;
        all_empty_next_s = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            // Recirculated data owns the output slot, so the head stays put.
            pop_s[i] = ~recirc_valid_s[i] & (count_r[i] != CNT_ZERO);
            if (state_r == ST_ERROR) begin
                push_s[i] = 1'b0;
                ovf_s[i]  = 1'b0;
            end else if ((count_r[i] == CNT_FULL) && !pop_s[i]) begin
                push_s[i] = 1'b0;
                ovf_s[i]  = valid_in_s[i];
            end else begin
                push_s[i] = valid_in_s[i];
                ovf_s[i]  = 1'b0;
            end
            case ({push_s[i], pop_s[i]})
                2'b10:   count_next_s[i] = count_r[i] + CNT_ONE;
                2'b01:   count_next_s[i] = count_r[i] - CNT_ONE;
                default: count_next_s[i] = count_r[i];
            endcase
            any_high_s       = any_high_s | (count_next_s[i] >= CNT_HIGH);
            all_empty_next_s = all_empty_next_s & (count_next_s[i] == CNT_ZERO);
        end
    end

    // Control FSM next-state; overflow overrides every other transition
    always_comb begin
        state_fsm_s = state_r;
        case (state_r)
            ST_RESET: begin
                state_fsm_s = ST_IDLE;
            end
            ST_IDLE: begin
                if (any_valid_s) begin
                    state_fsm_s = ST_ACTIVE;
                end else begin
                    state_fsm_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (!any_valid_s && all_empty_next_s) begin
                    state_fsm_s = ST_IDLE;
                end else begin
                    state_fsm_s = ST_ACTIVE;
                end
            end
            ST_ERROR: begin
                state_fsm_s = ST_ERROR;
            end
            default: begin
                state_fsm_s = ST_ERROR;
            end
        endcase
        if (overflow_s) begin
            state_next_s = ST_ERROR;
        end else begin
            state_next_s = state_fsm_s;
        end
    end

    // Control FSM state register
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_r <= ST_RESET;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < LANES; i++) begin
                rd_ptr_r[i] <= {AW{1'b0}};
                wr_ptr_r[i] <= {AW{1'b0}};
                count_r[i]  <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (push_s[i]) begin
                    wr_ptr_r[i] <= wr_ptr_r[i] + PTR_ONE;
                end
                if (pop_s[i]) begin
                    rd_ptr_r[i] <= rd_ptr_r[i] + PTR_ONE;
                end
                count_r[i] <= count_next_s[i];
            end
        end
    end

    // FIFO storage write; contents need no reset since a zero count hides them
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (push_s[i]) begin
                mem_r[i][wr_ptr_r[i]] <= data_in_s[i];
            end
        end
    end

    // Lane output registers: recirculated data first, then FIFO head, else hold data
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < LANES; i++) begin
                data_out_r[i] <= {DATA_WIDTH{1'b0}};
            end
            valid_out_r <= {LANES{1'b0}};
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (recirc_valid_s[i]) begin
                    data_out_r[i]  <= recirc_in_s[i];
                    valid_out_r[i] <= 1'b1;
                end else if (pop_s[i]) begin
                    data_out_r[i]  <= mem_r[i][rd_ptr_r[i]];
                    valid_out_r[i] <= 1'b1;
                end else begin
                    valid_out_r[i] <= 1'b0;
                end
            end
        end
    end

    // Status outputs registered from the next state so they line up with the state
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            selector_idle_r <= 1'b0;
            pause_r         <= 1'b0;
            error_r         <= 1'b0;
        end else begin
            selector_idle_r <= (state_next_s == ST_IDLE);
            pause_r         <= any_high_s | (state_next_s == ST_ERROR);
            error_r         <= (state_next_s == ST_ERROR);
        end
    end

    assign dataOut0      = data_out_r[0];
    assign dataOut1      = data_out_r[1];
    assign dataOut2      = data_out_r[2];
    assign dataOut3      = data_out_r[3];
    assign validOut0     = valid_out_r[0];
    assign validOut1     = valid_out_r[1];
    assign validOut2     = valid_out_r[2];
    assign validOut3     = valid_out_r[3];
    assign selector_IDLE = selector_idle_r;
    assign pause         = pause_r;
    assign error         = error_r;

endmodule
